// File: rtl/priv_1_11_hpm_csr_bank_pkg.sv
// Shared types and CSR address map for the machine-mode counter bank.
package machine_mode_types_1_11_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3     = 12'h323;
    localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3   = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH      = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3H  = 12'hB83;
    localparam logic [11:0] CSR_CYCLE          = 12'hC00;
    localparam logic [11:0] CSR_INSTRET        = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER3    = 12'hC03;
    localparam logic [11:0] CSR_CYCLEH         = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH       = 12'hC82;
    localparam logic [11:0] CSR_HPMCOUNTER3H   = 12'hC83;
    localparam logic [11:0] MHPMOVF_ADDR       = 12'h7C0;

    // Bit layout shared by mcountinhibit and the overflow flag register.
    typedef struct packed {
        logic [28:0] hpm;
        logic        ir;
        logic        tm;
        logic        cy;
    } mcountinhibit_t;

    typedef enum logic [2:0] {
        RegNone, RegInhibit, RegEvent, RegCntLo, RegCntHi, RegAliasLo, RegAliasHi, RegOvf
    } csr_region_e;

    // Counter slice index (0 = mcycle, 1 = minstret, 2+i = hpm i) to CSR bit position.
    function automatic logic [4:0] ctr_pos(input int unsigned k);
        return (k == 0) ? 5'd0 : 5'(k + 1);
    endfunction

endpackage

// File: rtl/priv_1_11_hpm_csr_bank_if.sv
// CSR access port shared between the pipeline (master) and the counter bank (slave).
interface priv_1_11_hpm_csr_bank_if;
    logic [11:0] csr_addr;
    logic        csr_swap;
    logic        csr_set;
    logic        csr_clr;
    logic        csr_valid_write;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        csr_invalid;

    modport master (
        output csr_addr, csr_swap, csr_set, csr_clr, csr_valid_write, csr_wdata,
        input  csr_rdata, csr_hit, csr_invalid
    );

    modport slave (
        input  csr_addr, csr_swap, csr_set, csr_clr, csr_valid_write, csr_wdata,
        output csr_rdata, csr_hit, csr_invalid
    );
endinterface

// File: rtl/priv_1_11_hpm_csr_bank_counter.sv
// One counter slice: CSR half-writes take priority over counting; ovf_o pulses on wrap.
module priv_1_11_hpm_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc_i,
    input  logic             inhibit_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [Width-1:0] value_o,
    output logic             ovf_o
);
    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: a write cycle suppresses the increment.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[Width-1:32] = wdata_i[Width-33:0];
        end else if (inc_i && !inhibit_i) begin
            cnt_d = cnt_q + Width'(1);
            ovf_o = &cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;
endmodule

// File: rtl/priv_1_11_hpm_csr_bank.sv
// Machine-mode counter bank: mcycle, minstret, NUM_HPM hpm counters, event selectors,
// mcountinhibit. Optional overflow flags/interrupt via define HPM_OVERFLOW_IRQ_EN.
module priv_1_11_hpm_csr_bank
    import machine_mode_types_1_11_pkg::*;
#(
    parameter int unsigned NUM_HPM       = 4,
    parameter int unsigned NUM_EVENTS    = 8,
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                          CLK,
    input  logic                          nRST,
    priv_1_11_hpm_csr_bank_if.slave       csr,
    input  logic                          instr_retired,
    input  logic [NUM_EVENTS-1:0]         events,
    output logic                          hpm_irq
);
    localparam int unsigned NumCtr  = NUM_HPM + 2;
    localparam int unsigned EvW     = $clog2(NUM_EVENTS + 1);
    localparam int unsigned EvExtW  = 2 ** EvW;
    localparam logic [31:0] InhMask = (((32'd1 << NUM_HPM) - 32'd1) << 3) | 32'h5;

    csr_region_e        region;
    logic [4:0]         pos, ctr_idx;
    logic               pos_hpm_ok, pos_ctr_ok, hit, op, is_alias, wen;
    logic [31:0]        rdata, wval, ovf_word;
    mcountinhibit_t     inhibit_q, inhibit_d;
    logic [EvW-1:0]     evsel_q [NUM_HPM];
    logic [EvW-1:0]     evsel_d [NUM_HPM];
    logic [EvExtW-1:0]  ev_ext;
    logic [COUNTER_WIDTH-1:0] cnt [NumCtr];
    logic [NumCtr-1:0]  ctr_inc, ctr_inh, ctr_wr_lo, ctr_wr_hi, ctr_ovf;

    assign pos        = csr.csr_addr[4:0];
    assign pos_hpm_ok = (pos >= 5'd3) && (32'(pos) < NUM_HPM + 3);
    assign pos_ctr_ok = (pos == 5'd0) || (pos == 5'd2) || pos_hpm_ok;
    assign ctr_idx    = (pos == 5'd0) ? 5'd0 : pos - 5'd1;

    // Address decode into a register region.
    always_comb begin
        region = RegNone;
        if (csr.csr_addr == CSR_MCOUNTINHIBIT) begin
            region = RegInhibit;
        end else if (csr.csr_addr[11:5] == CSR_MHPMEVENT3[11:5] && pos_hpm_ok) begin
            region = RegEvent;
        end else if (pos_ctr_ok) begin
            case (csr.csr_addr[11:5])
                CSR_MCYCLE[11:5]:  region = RegCntLo;
                CSR_MCYCLEH[11:5]: region = RegCntHi;
                CSR_CYCLE[11:5]:   region = RegAliasLo;
                CSR_CYCLEH[11:5]:  region = RegAliasHi;
                default:           region = RegNone;
            endcase
        end
`ifdef HPM_OVERFLOW_IRQ_EN
        if (csr.csr_addr == MHPMOVF_ADDR) region = RegOvf;
`endif
    end

    // Read mux; high halves zero-extend.
    always_comb begin
        rdata = '0;
        unique case (region)
            RegInhibit: rdata = inhibit_q;
            RegEvent: begin
                for (int unsigned i = 0; i < NUM_HPM; i++)
                    if (32'(pos) == i + 3) rdata = 32'(evsel_q[i]);
            end
            RegCntLo, RegAliasLo: begin
                for (int unsigned k = 0; k < NumCtr; k++)
                    if (32'(ctr_idx) == k) rdata = cnt[k][31:0];
            end
            RegCntHi, RegAliasHi: begin
                for (int unsigned k = 0; k < NumCtr; k++)
                    if (32'(ctr_idx) == k) rdata = 32'(cnt[k][COUNTER_WIDTH-1:32]);
            end
            RegOvf:  rdata = ovf_word;
            default: rdata = '0;
        endcase
    end

    assign hit      = (region != RegNone);
    assign op       = csr.csr_swap | csr.csr_set | csr.csr_clr;
    assign is_alias = (region == RegAliasLo) || (region == RegAliasHi);
    assign wen      = op & hit & csr.csr_valid_write & ~is_alias;

    assign csr.csr_rdata   = rdata;
    assign csr.csr_hit     = hit;
    assign csr.csr_invalid = op & (~hit | (is_alias & csr.csr_valid_write &
                                           (csr.csr_swap | (csr.csr_wdata != '0))));

    // Swap/set/clear write value.
    always_comb begin
        if (csr.csr_swap)     wval = csr.csr_wdata;
        else if (csr.csr_set) wval = rdata | csr.csr_wdata;
        else                  wval = rdata & ~csr.csr_wdata;
    end

    // WARL updates of mcountinhibit and event selectors (illegal event code stores 0).
    always_comb begin
        inhibit_d = inhibit_q;
        evsel_d   = evsel_q;
        if (wen && region == RegInhibit) inhibit_d = mcountinhibit_t'(wval & InhMask);
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (wen && region == RegEvent && 32'(pos) == i + 3)
                evsel_d[i] = (wval > 32'(NUM_EVENTS)) ? '0 : wval[EvW-1:0];
        end
    end

    // Configuration registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            inhibit_q <= '0;
            evsel_q   <= '{default: '0};
        end else begin
            inhibit_q <= inhibit_d;
            evsel_q   <= evsel_d;
        end
    end

    // Bit 0 of the extended bus is a constant zero so selector 0 never counts.
    assign ev_ext = EvExtW'({events, 1'b0});

    // Per-slice increment, inhibit and write enables.
    always_comb begin
        ctr_inc[0] = 1'b1;
        ctr_inh[0] = inhibit_q.cy;
        ctr_inc[1] = instr_retired;
        ctr_inh[1] = inhibit_q.ir;
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            ctr_inc[i+2] = ev_ext[evsel_q[i]];
            ctr_inh[i+2] = inhibit_q.hpm[i];
        end
        for (int unsigned k = 0; k < NumCtr; k++) begin
            ctr_wr_lo[k] = wen && (region == RegCntLo) && (32'(ctr_idx) == k);
            ctr_wr_hi[k] = wen && (region == RegCntHi) && (32'(ctr_idx) == k);
        end
    end

    for (genvar k = 0; k < NumCtr; k++) begin : g_ctr
        priv_1_11_hpm_counter #(
            .Width(COUNTER_WIDTH)
        ) u_ctr (
            .CLK       (CLK),
            .nRST      (nRST),
            .inc_i     (ctr_inc[k]),
            .inhibit_i (ctr_inh[k]),
            .wr_lo_i   (ctr_wr_lo[k]),
            .wr_hi_i   (ctr_wr_hi[k]),
            .wdata_i   (csr.csr_wdata),
            .value_o   (cnt[k]),
            .ovf_o     (ctr_ovf[k])
        );
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic [NumCtr-1:0] ovf_q, ovf_d;
    logic [31:0]       ovf_clr_mask;

    // Write-1-to-clear; clr op leaves flags alone.
    assign ovf_clr_mask = (wen && region == RegOvf && !csr.csr_clr) ? csr.csr_wdata : '0;

    // Sticky flags: a wrap in the same cycle as a clear wins.
    always_comb begin
        ovf_word = '0;
        for (int unsigned k = 0; k < NumCtr; k++) begin
            ovf_word[ctr_pos(k)] = ovf_q[k];
            ovf_d[k] = ctr_ovf[k] | (ovf_q[k] & ~ovf_clr_mask[ctr_pos(k)]);
        end
    end

    // Overflow flag register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign hpm_irq = |ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ^ctr_ovf;
    assign ovf_word   = '0;
    assign hpm_irq    = 1'b0;
`endif
endmodule

// File: tb/tb_priv_1_11_hpm_csr_bank.sv
// Bench for the machine-mode counter bank (default parameters).
module tb_priv_1_11_hpm_csr_bank;
    localparam logic [2:0] OpNone = 3'b000, OpSwap = 3'b001, OpSet = 3'b010, OpClr = 3'b100;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [2:0]  op;
        logic        vw;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_inv;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        hit;
        logic        inv;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       instr_retired;
    logic [7:0] events;
    logic       hpm_irq;
    int         n_checks = 0;
    int         n_pass = 0;
    vec_t       vecs[$];
    exp_t       sb[$];

    priv_1_11_hpm_csr_bank_if bus ();

    priv_1_11_hpm_csr_bank #(
        .NUM_HPM       (4),
        .NUM_EVENTS    (8),
        .COUNTER_WIDTH (64)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .csr           (bus),
        .instr_retired (instr_retired),
        .events        (events),
        .hpm_irq       (hpm_irq)
    );

    always #5 CLK = ~CLK;

    function automatic void add(input string n, input logic [11:0] a, input logic [2:0] op,
                                input logic vw, input logic [31:0] wd, input logic [31:0] r,
                                input logic h, input logic inv);
        vec_t v;
        v.name = n; v.addr = a; v.op = op; v.vw = vw; v.wdata = wd;
        v.exp_rdata = r; v.exp_hit = h; v.exp_inv = inv;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [11:0] a, input logic [2:0] op, input logic vw,
                         input logic [31:0] wd);
        bus.csr_addr        = a;
        bus.csr_swap        = op[0];
        bus.csr_set         = op[1];
        bus.csr_clr         = op[2];
        bus.csr_valid_write = vw;
        bus.csr_wdata       = wd;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Expectation goes into the scoreboard with the stimulus, compared once outputs settle.
    task automatic expect_csr(input string n, input logic [31:0] r, input logic h,
                              input logic inv);
        exp_t e;
        e.name = n; e.rdata = r; e.hit = h; e.inv = inv;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.csr_rdata !== e.rdata || bus.csr_hit !== e.hit || bus.csr_invalid !== e.inv)
            $display("FAIL %s: got rdata=%h hit=%b inv=%b, want rdata=%h hit=%b inv=%b",
                     e.name, bus.csr_rdata, bus.csr_hit, bus.csr_invalid, e.rdata, e.hit, e.inv);
        else
            n_pass++;
    endtask

    task automatic peek(input string n, input logic [11:0] a, input logic [31:0] r);
        drive(a, OpNone, 1'b0, 32'h0);
        expect_csr(n, r, 1'b1, 1'b0);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [2:0] op, input logic [31:0] wd);
        drive(a, op, 1'b1, wd);
        tick(1);
        drive(12'h000, OpNone, 1'b0, 32'h0);
    endtask

    task automatic check_irq(input string n, input logic e);
        n_checks++;
        if (hpm_irq !== e) $display("FAIL %s: got hpm_irq=%b, want %b", n, hpm_irq, e);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        instr_retired = 1'b0;
        events = '0;
        drive(12'h000, OpNone, 1'b0, 32'h0);

        add("evsel3_rst",     12'h323, OpNone, 0, 32'h0,        32'h0,  1, 0);
        add("evsel4_rst",     12'h324, OpNone, 0, 32'h0,        32'h0,  1, 0);
        add("evsel5_rst",     12'h325, OpNone, 0, 32'h0,        32'h0,  1, 0);
        add("evsel6_rst",     12'h326, OpNone, 0, 32'h0,        32'h0,  1, 0);
        add("evsel7_nodec",   12'h327, OpNone, 0, 32'h0,        32'h0,  0, 0);
        add("a321_nodec",     12'h321, OpNone, 0, 32'h0,        32'h0,  0, 0);
        add("inhibit_rst",    12'h320, OpNone, 0, 32'h0,        32'h0,  1, 0);
        add("inhibit_swap",   12'h320, OpSwap, 1, 32'hFFFFFFFF, 32'h0,  1, 0);
        add("inhibit_warl",   12'h320, OpNone, 0, 32'h0,        32'h7D, 1, 0);
        add("inhibit_clr",    12'h320, OpClr,  1, 32'hFFFFFFFF, 32'h7D, 1, 0);
        add("inhibit_zero",   12'h320, OpNone, 0, 32'h0,        32'h0,  1, 0);
        add("evsel3_swap",    12'h323, OpSwap, 1, 32'h2,        32'h0,  1, 0);
        add("evsel3_read",    12'h323, OpNone, 0, 32'h0,        32'h2,  1, 0);
        add("evsel4_illegal", 12'h324, OpSwap, 1, 32'h9,        32'h0,  1, 0);
        add("evsel4_warl",    12'h324, OpNone, 0, 32'h0,        32'h0,  1, 0);
        add("evsel4_set_max", 12'h324, OpSet,  1, 32'h8,        32'h0,  1, 0);
        add("evsel4_max",     12'h324, OpNone, 0, 32'h0,        32'h8,  1, 0);
        add("evsel4_clr",     12'h324, OpClr,  1, 32'h8,        32'h8,  1, 0);
        add("evsel4_cleared", 12'h324, OpNone, 0, 32'h0,        32'h0,  1, 0);
`ifdef HPM_OVERFLOW_IRQ_EN
        add("ovf_decoded",    12'h7C0, OpSwap, 1, 32'h0,        32'h0,  1, 0);
`else
        add("ovf_nodec",      12'h7C0, OpSwap, 1, 32'h0,        32'h0,  0, 1);
`endif
        add("unmapped_read",  12'h000, OpNone, 0, 32'h0,        32'h0,  0, 0);
        add("unmapped_set",   12'h333, OpSet,  1, 32'h1,        32'h0,  0, 1);
        add("alias_novw",     12'hC03, OpSwap, 0, 32'h5,        32'h0,  1, 0);
        add("aliash_swap",    12'hC83, OpSwap, 1, 32'h5,        32'h0,  1, 1);
        add("alias_set0",     12'hC04, OpSet,  1, 32'h0,        32'h0,  1, 0);
        add("hi_clr0",        12'hB85, OpClr,  1, 32'h0,        32'h0,  1, 0);
        add("ctr7_nodec",     12'hB07, OpNone, 0, 32'h0,        32'h0,  0, 0);
        add("time_nodec",     12'hB01, OpNone, 0, 32'h0,        32'h0,  0, 0);

        // Reset state, then 10 free-running cycles.
        tick(2);
        peek("rst_mcycle", 12'hB00, 32'h0);
        peek("rst_evsel3", 12'h323, 32'h0);
        check_irq("rst_irq", 1'b0);
        nRST = 1'b1;
        tick(10);
        peek("mcycle_10", 12'hB00, 32'd10);
        peek("mcycleh_0", 12'hB80, 32'h0);
        tick(1);

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].op, vecs[i].vw, vecs[i].wdata);
            expect_csr(vecs[i].name, vecs[i].exp_rdata, vecs[i].exp_hit, vecs[i].exp_inv);
            tick(1);
        end
        drive(12'h000, OpNone, 1'b0, 32'h0);

        // Event counting on hpm3 (selector 2 -> events[1]).
        events = 8'h02; tick(1); events = 8'h00;
        peek("hpm3_one", 12'hB03, 32'd1);
        repeat (4) begin
            events = 8'h02; tick(1); events = 8'h00;
        end
        peek("hpm3_five", 12'hB03, 32'd5);
        events = 8'h01; tick(2); events = 8'h00;
        peek("hpm3_other_ev", 12'hB03, 32'd5);
        peek("hpm4_idle", 12'hB04, 32'd0);
        tick(1);

        // minstret inhibit and resume.
        peek("minstret_zero", 12'hB02, 32'd0);
        csr_write(12'h320, OpSet, 32'h4);
        instr_retired = 1'b1; tick(4); instr_retired = 1'b0;
        peek("minstret_inhibited", 12'hB02, 32'd0);
        csr_write(12'h320, OpClr, 32'h4);
        instr_retired = 1'b1; tick(3); instr_retired = 1'b0;
        peek("minstret_resumed", 12'hB02, 32'd3);

        // mcycle write while inhibited; no increment in the cycle inhibit clears.
        csr_write(12'h320, OpSet, 32'h1);
        csr_write(12'hB00, OpSwap, 32'd100);
        tick(3);
        peek("mcycle_inhibited", 12'hB00, 32'd100);
        csr_write(12'h320, OpClr, 32'h1);
        tick(4);
        peek("mcycle_resumed", 12'hB00, 32'd104);

        // Full 64-bit wrap of hpm3.
        csr_write(12'hB03, OpSwap, 32'hFFFFFFFF);
        csr_write(12'hB83, OpSwap, 32'hFFFFFFFF);
        peek("hpm3_lo_max", 12'hB03, 32'hFFFFFFFF);
        peek("hpm3_hi_max", 12'hB83, 32'hFFFFFFFF);
        check_irq("irq_no_write_ovf", 1'b0);
        events = 8'h02; tick(1); events = 8'h00;
        peek("hpm3_lo_wrap", 12'hB03, 32'h0);
        peek("hpm3_hi_wrap", 12'hB83, 32'h0);
`ifdef HPM_OVERFLOW_IRQ_EN
        check_irq("irq_set", 1'b1);
        peek("ovf_flags", 12'h7C0, 32'h8);
        csr_write(12'h7C0, OpSwap, 32'h8);
        check_irq("irq_cleared", 1'b0);
`else
        check_irq("irq_tied_low", 1'b0);
`endif

        // Illegal event code on a live selector.
        drive(12'h323, OpSwap, 1'b1, 32'd9);
        expect_csr("evsel3_old", 32'h2, 1'b1, 1'b0);
        tick(1);
        peek("evsel3_warl", 12'h323, 32'h0);

        // Read-only user alias.
        csr_write(12'hB00, OpSwap, 32'd1000);
        drive(12'hC00, OpSwap, 1'b1, 32'h5);
        expect_csr("alias_swap_c00", 32'd1000, 1'b1, 1'b1);
        tick(1);
        drive(12'hC00, OpSet, 1'b1, 32'h0);
        expect_csr("alias_csrrs0", 32'd1001, 1'b1, 1'b0);
        tick(1);

        // Async reset mid-count with a write pending across the edge.
        events = 8'h02;
        instr_retired = 1'b1;
        drive(12'hB02, OpSwap, 1'b1, 32'h55);
        #2 nRST = 1'b0;
        expect_csr("rst_async_minstret", 32'h0, 1'b1, 1'b0);
        tick(1);
        peek("rst_mcycle2", 12'hB00, 32'h0);
        peek("rst_hpm3", 12'hB03, 32'h0);
        peek("rst_evsel3b", 12'h323, 32'h0);
        peek("rst_inhibit", 12'h320, 32'h0);
        check_irq("rst_irq2", 1'b0);
        events = 8'h00;
        instr_retired = 1'b0;
        nRST = 1'b1;
        tick(2);
        peek("post_rst_minstret", 12'hB02, 32'h0);
        peek("post_rst_mcycle", 12'hB00, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
